// File: rtl/cnn_pkg.sv
// Shared CNN constants and pooling-stage state type, also used by the FC stage.
package cnn_pkg;

    localparam int DATA_W = 32;
    localparam int MAP_W  = 6;
    localparam int HALF_W = MAP_W / 2;
    localparam int N      = HALF_W * HALF_W;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } pool_state_t;

endpackage

// File: rtl/signed_max2.sv
// Combinational signed maximum of two operands; used for both the row and column pooling steps.
module signed_max2 #(
    parameter int DATA_W = cnn_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] max_val
);

    assign max_val = (a > b) ? a : b;

endmodule

// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 max pooling of a streamed square frame into a flat vector held until
// the consumer acknowledges it.
module maxpool_flatten #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int MAP_W  = cnn_pkg::MAP_W
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic signed [DATA_W-1:0]                  in_pix,
    input  logic                                      in_last,
    output logic                                      in_ready,
    output logic [(MAP_W/2)*(MAP_W/2)*DATA_W-1:0]     pool_out,
    output logic                                      out_valid,
    input  logic                                      out_ack,
    output logic                                      frame_err
);

    import cnn_pkg::*;

    localparam int HALF = MAP_W / 2;
    localparam int NOUT = HALF * HALF;
    localparam int CW   = $clog2(MAP_W);
    localparam int HW   = CW - 1;

    pool_state_t state_reg, state_next;

    logic [CW-1:0] col_reg, col_next;
    logic [CW-1:0] row_reg, row_next;
    logic          frame_err_reg, frame_err_next;

    logic signed [DATA_W-1:0] pair_reg;
    logic signed [DATA_W-1:0] partial_reg [HALF];
    logic signed [DATA_W-1:0] pool_reg [NOUT];

    logic signed [DATA_W-1:0] partial_sel;
    logic signed [DATA_W-1:0] pair_max;
    logic signed [DATA_W-1:0] pool_max;

    logic [HALF-1:0] partial_we;
    logic [NOUT-1:0] pool_we;

    logic          accept;
    logic          last_pos;
    logic          good_end;
    logic          bad_end;
    logic [HW-1:0] col_half;
    logic [HW-1:0] row_half;

    assign accept   = in_valid & in_ready;
    assign last_pos = (row_reg == CW'(MAP_W - 1)) && (col_reg == CW'(MAP_W - 1));
    assign good_end = accept && last_pos && in_last;
    // A misplaced or missing in_last both abort the frame the same way.
    assign bad_end  = accept && (last_pos != in_last);
    assign col_half = col_reg[CW-1:1];
    assign row_half = row_reg[CW-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (good_end) state_next = HOLD;
            HOLD:    if (out_ack)  state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // in_ready is gated by rst directly so nothing is accepted during a reset cycle.
    always_comb begin
        in_ready  = (state_reg == COLLECT) && !rst;
        out_valid = (state_reg == HOLD);
    end

    always_comb begin
        col_next       = col_reg;
        row_next       = row_reg;
        frame_err_next = bad_end;
        if ((state_reg == HOLD && out_ack) || good_end || bad_end) begin
            col_next = '0;
            row_next = '0;
        end else if (accept) begin
            if (col_reg == CW'(MAP_W - 1)) begin
                col_next = '0;
                row_next = row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg       <= '0;
            row_reg       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign frame_err = frame_err_reg;

    always_comb begin
        partial_sel = '0;
        for (int i = 0; i < HALF; i++) begin
            if (col_half == HW'(i)) partial_sel = partial_reg[i];
        end
    end

    signed_max2 #(.DATA_W(DATA_W)) u_hmax (
        .a       (pair_reg),
        .b       (in_pix),
        .max_val (pair_max)
    );

    signed_max2 #(.DATA_W(DATA_W)) u_vmax (
        .a       (partial_sel),
        .b       (pair_max),
        .max_val (pool_max)
    );

    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_partial_we
            assign partial_we[gi] = accept && !row_reg[0] && col_reg[0] && (col_half == HW'(gi));
        end
        for (gi = 0; gi < NOUT; gi++) begin : g_pool
            assign pool_we[gi] = accept && row_reg[0] && col_reg[0]
                                 && (row_half == HW'(gi / HALF)) && (col_half == HW'(gi % HALF));
            assign pool_out[gi*DATA_W +: DATA_W] = pool_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_reg <= '0;
            for (int i = 0; i < HALF; i++) partial_reg[i] <= '0;
            for (int i = 0; i < NOUT; i++) pool_reg[i] <= '0;
        end else begin
            if (accept && !col_reg[0]) pair_reg <= in_pix;
            for (int i = 0; i < HALF; i++) begin
                if (partial_we[i]) partial_reg[i] <= pair_max;
            end
            for (int i = 0; i < NOUT; i++) begin
                if (pool_we[i]) pool_reg[i] <= pool_max;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Scoreboard bench for maxpool_flatten: directed frames push expected vectors, a monitor checks them.
module tb_maxpool_flatten;

    localparam int DW = 32;
    localparam int MW = 6;
    localparam int NN = 9;
    localparam int PW = NN * DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [DW-1:0] in_pix;
    logic                 in_last;
    logic                 in_ready;
    logic [PW-1:0]        pool_out;
    logic                 out_valid;
    logic                 out_ack;
    logic                 frame_err;

    int tests = 0;
    int fails = 0;

    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] ramp_vec;
    logic [PW-1:0] neg_vec;
    logic [PW-1:0] mon_exp;
    logic          mon_prev;
    int            ramp_exp [NN] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

    always #5 clk = ~clk;

    maxpool_flatten #(.DATA_W(DW), .MAP_W(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pix    (in_pix),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .pool_out  (pool_out),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pix_val(input int kind, input int p);
        if (kind == 0) return p;
        return (((p / MW) % 2 == 1) && ((p % MW) % 2 == 0)) ? -5 : -1000;
    endfunction

    task automatic send_pix(input int val, input logic last);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_pix   = val;
        in_last  = last;
        while (!in_ready && waitc < 20) begin
            step();
            waitc++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: got in_ready=0 for 20 cycles, required 1");
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_range(input int kind, input int first, input int last_p,
                              input int last_at, input bit gapped);
        for (int p = first; p <= last_p; p++) begin
            if (gapped) begin
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) step();
            end
            send_pix(pix_val(kind, p), p == last_at);
        end
    endtask

    // Full good frame: push the expected vector, stream it, then check the hand-off latency.
    task automatic good_frame(input int kind, input bit gapped, input logic [PW-1:0] exp);
        exp_q.push_back(exp);
        send_range(kind, 0, MW*MW-1, MW*MW-1, gapped);
        check("out_valid_latency", out_valid, 1'b1);
        check("in_ready_in_hold", in_ready, 1'b0);
    endtask

    task automatic ack();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("out_valid_after_ack", out_valid, 1'b0);
        check("in_ready_after_ack", in_ready, 1'b1);
    endtask

    initial begin
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_out: got pool_out=%h, required no output", pool_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    $display("[TB] frame out pool_out=%h", pool_out);
                    check("pool_out", pool_out, mon_exp);
                end
            end
            mon_prev = out_valid;
        end
    end

    initial begin
        for (int k = 0; k < NN; k++) begin
            ramp_vec[k*DW +: DW] = ramp_exp[k];
            neg_vec[k*DW +: DW]  = -5;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pix   = '0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        step();
        step();
        check("in_ready_in_reset", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_pool_out", pool_out, '0);
        check("reset_in_ready", in_ready, 1'b1);

        $display("[TB] ramp frame");
        good_frame(0, 1'b0, ramp_vec);
        ack();

        $display("[TB] negative frame");
        good_frame(1, 1'b0, neg_vec);
        ack();

        $display("[TB] backpressure");
        good_frame(0, 1'b0, ramp_vec);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_pix   = $urandom;
            in_last  = c[0];
            step();
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_pool_out", pool_out, ramp_vec);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ack();
        good_frame(0, 1'b0, ramp_vec);
        ack();

        $display("[TB] early in_last on pixel 20");
        send_range(0, 0, 20, 20, 1'b0);
        check("early_last_err", frame_err, 1'b1);
        check("early_last_no_valid", out_valid, 1'b0);
        step();
        check("early_last_err_pulse", frame_err, 1'b0);
        good_frame(0, 1'b0, ramp_vec);
        ack();

        $display("[TB] missing in_last");
        send_range(0, 0, MW*MW-1, -1, 1'b0);
        check("missing_last_err", frame_err, 1'b1);
        check("missing_last_no_valid", out_valid, 1'b0);
        step();
        check("missing_last_err_pulse", frame_err, 1'b0);
        good_frame(0, 1'b0, ramp_vec);
        ack();

        $display("[TB] out_ack during collect");
        exp_q.push_back(ramp_vec);
        send_range(0, 0, 9, -1, 1'b0);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        send_range(0, 10, MW*MW-1, MW*MW-1, 1'b0);
        check("ack_ignored_valid", out_valid, 1'b1);
        ack();

        $display("[TB] reset mid-frame");
        send_range(0, 0, 16, -1, 1'b0);
        rst = 1'b1;
        #1;
        check("midreset_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("midreset_pool_out", pool_out, '0);
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        good_frame(0, 1'b0, ramp_vec);
        ack();

        $display("[TB] reset in hold");
        good_frame(1, 1'b0, neg_vec);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("holdreset_out_valid", out_valid, 1'b0);
        check("holdreset_in_ready", in_ready, 1'b1);

        $display("[TB] gapped ramp frame");
        good_frame(0, 1'b1, ramp_vec);
        ack();

        step();
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
